axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 subordinate backing store for the data-cache AXI initiator ports: serves refill bursts (AR/R), write-back bursts (AW/W/B) and single-beat bypass accesses.
- Used in cache-subsystem benches and FPGA bring-up as the far end of the data and bypass AXI ports.
- Single-port word-wide memory; one transaction is in flight at a time.
- Read and write channels are arbitrated round-robin.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; AxiDataWidth, AxiAddrWidth and AxiIdWidth are taken from it.
- axi_req_t, logic, AXI request struct type (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- axi_rsp_t, logic, AXI response struct type (aw_ready, ar_ready, w_ready, b_valid, b, r_valid, r).
- NumWords, 1024, memory depth in AxiDataWidth-bit words.
- BaseAddr, 64'h8000_0000, byte address of word 0.
- ReadLatency, 0, extra wait cycles before the first R beat of each burst (0..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- axi_req_i  in  $bits(axi_req_t)  AXI request from the initiator.
- axi_rsp_o  out  $bits(axi_rsp_t)  AXI response to the initiator.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all valid and ready outputs are 0, all response payloads are 0, busy_o=0, FSM=IDLE, round-robin pointer favours AR.
- Memory contents are undefined after reset.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_DATA, WR_RESP.
- IDLE:
  - ar_ready and aw_ready are asserted only in IDLE, and only for the channel chosen by round-robin when both are valid. Otherwise the ready goes to whichever channel is valid.
  - After a grant, the pointer favours the other channel.
  - Accepted ar/aw is latched: id, addr, len, size, burst. The beat counter is cleared.
- AR accepted -> RD_WAIT. The wait counter is loaded with ReadLatency.
- RD_WAIT:
  - Count down to 0, then issue a memory read for the current beat address and go to RD_BEAT.
  - Memory read latency is 1 cycle. r_valid rises the cycle after the read is issued.
  - With ReadLatency=0, r_valid is first asserted 2 cycles after the AR handshake.
- RD_BEAT:
  - r_valid=1; r.data, r.id, r.resp and r.last are held stable until r_ready.
  - r.last=1 when beat counter == len.
  - On handshake with last -> IDLE. Otherwise advance the address, issue the next read, and stay in RD_BEAT with r_valid=0 for 1 cycle. Steady state is 1 beat per 2 cycles.
- AW accepted -> WR_DATA.
- WR_DATA:
  - w_ready=1. Each handshake writes the beat with w.strb as the byte enable, then advances the address and counter.
  - The beat with counter == len moves to WR_RESP, regardless of w.last.
  - If w.last disagrees with counter == len, the transaction error flag is set.
- WR_RESP: b_valid=1 with the latched id and resp; held until b_ready, then -> IDLE.
- Address rules:
  - Word index = (addr - BaseAddr) >> log2(AxiDataWidth/8).
  - INCR bursts: addr += 1<<size per beat.
  - FIXED bursts: addr is unchanged.
  - WRAP bursts: the whole transaction is an error.
- Errors:
  - A beat out of range (addr < BaseAddr or index >= NumWords) gives resp=SLVERR for that R beat, with data 0.
  - Out-of-range writes are suppressed.
  - B resp is SLVERR if any beat erred, WRAP was used, or the last mismatch occurred; otherwise OKAY.
  - Beat count is always len+1.
- aw.atop must be 0; a non-zero atop is a bench protocol error and is not checked.
- user fields in responses are driven 0.
- rst_i mid-burst: immediate return to IDLE, all valid outputs drop asynchronously, and the partial burst is abandoned.
- Round-robin pointer updates only on an actual grant.

Test Plan:
- Write then refill: AW addr=0x8000_0040, len=1, size=3, INCR; W 0x1111..., 0x2222..., strb=0xFF. Then AR at the same address, len=1 -> B OKAY; R beats 0x1111..., 0x2222... with last on beat 1; first r_valid 2 cycles after the AR handshake.
- Backpressure and latency: ReadLatency=3, r_ready low for 5 cycles on beat 0 -> data, id and last stay stable; first r_valid 5 cycles after the AR handshake.
- Simultaneous AR and AW valid in the same cycle after reset -> AR granted first, AW granted after the read completes; a second simultaneous pair -> AW granted first.
- Out-of-range access:
  - AR addr=BaseAddr + NumWords*8 - 8, len=1 -> beat 0 OKAY, beat 1 SLVERR with data 0.
  - Write to 0x7FFF_FFF8 -> B SLVERR, memory unchanged.
- Byte strobes and last mismatch: write strb=0x0F over 0xFFFF... -> lower 4 bytes updated only. A len=1 write with w.last on beat 0 -> 2 beats accepted, B SLVERR.
- Reset mid-read: assert rst_i during RD_BEAT of a len=3 burst -> r_valid=0 and busy_o=0 immediately; a new AR after reset is served normally.

Source files
------------

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 subordinate word-wide memory for cache refill, write-back and bypass ports
package config_pkg;
  typedef struct packed {
    int unsigned AxiDataWidth;
    int unsigned AxiAddrWidth;
    int unsigned AxiIdWidth;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{AxiDataWidth: 64, AxiAddrWidth: 64, AxiIdWidth: 4};

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic        user;
  } axi_aw_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        user;
  } axi_ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;
endpackage

module axi_mem_responder #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type axi_req_t = config_pkg::axi_req_t,
  parameter type axi_rsp_t = config_pkg::axi_rsp_t,
  parameter int unsigned NumWords = 1024,
  parameter logic [63:0] BaseAddr = 64'h8000_0000,
  parameter int unsigned ReadLatency = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output logic     busy_o
);
  localparam int unsigned DW  = CVA6Cfg.AxiDataWidth;
  localparam int unsigned AW  = CVA6Cfg.AxiAddrWidth;
  localparam int unsigned IW  = CVA6Cfg.AxiIdWidth;
  localparam int unsigned NB  = DW / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned XW  = $clog2(NumWords);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_DATA, WR_RESP} state_e;

  state_e          state_q;
  logic            rr_q;
  logic [IW-1:0]   id_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q, cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [3:0]      wait_q;
  logic            err_q;
  logic            r_valid_q, r_last_q;
  logic [DW-1:0]   r_data_q;
  logic [1:0]      r_resp_q;
  logic            b_valid_q;
  logic [1:0]      b_resp_q;
  logic [DW-1:0]   mem_q [NumWords];

  logic [AW-1:0]   offs, next_addr;
  logic [XW-1:0]   idx;
  logic            in_range, beat_ok;
  logic            ar_gnt, aw_gnt, w_hs;

  // A WRAP burst poisons every beat of the transaction, like an out-of-range address.
  assign offs      = addr_q - AW'(BaseAddr);
  assign in_range  = (addr_q >= AW'(BaseAddr)) && ((offs >> OFF) < AW'(NumWords));
  assign beat_ok   = in_range && (burst_q != BURST_WRAP);
  assign idx       = offs[OFF +: XW];
  assign next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + (AW'(1) << size_q);

  // rr_q low favours AR when both address channels are valid.
  assign ar_gnt = (state_q == IDLE) && axi_req_i.ar_valid && (!axi_req_i.aw_valid || !rr_q);
  assign aw_gnt = (state_q == IDLE) && axi_req_i.aw_valid && (!axi_req_i.ar_valid || rr_q);
  assign w_hs   = (state_q == WR_DATA) && axi_req_i.w_valid;
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (w_hs && beat_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_req_i.w.strb[b]) mem_q[idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_gnt) begin
            id_q    <= axi_req_i.ar.id;
            addr_q  <= axi_req_i.ar.addr;
            len_q   <= axi_req_i.ar.len;
            size_q  <= axi_req_i.ar.size;
            burst_q <= axi_req_i.ar.burst;
            cnt_q   <= '0;
            wait_q  <= 4'(ReadLatency);
            rr_q    <= 1'b1;
            state_q <= RD_WAIT;
          end else if (aw_gnt) begin
            id_q    <= axi_req_i.aw.id;
            addr_q  <= axi_req_i.aw.addr;
            len_q   <= axi_req_i.aw.len;
            size_q  <= axi_req_i.aw.size;
            burst_q <= axi_req_i.aw.burst;
            cnt_q   <= '0;
            err_q   <= (axi_req_i.aw.burst == BURST_WRAP);
            rr_q    <= 1'b0;
            state_q <= WR_DATA;
          end
        end
        RD_WAIT: begin
          if (wait_q == 4'd0) state_q <= RD_BEAT;
          else                wait_q  <= wait_q - 4'd1;
        end
        RD_BEAT: begin
          // r_valid low here means the memory word for the current beat is being fetched.
          if (!r_valid_q) begin
            r_valid_q <= 1'b1;
            r_data_q  <= beat_ok ? mem_q[idx] : '0;
            r_resp_q  <= beat_ok ? RESP_OKAY : RESP_SLVERR;
            r_last_q  <= (cnt_q == len_q);
          end else if (axi_req_i.r_ready) begin
            r_valid_q <= 1'b0;
            if (r_last_q) begin
              state_q <= IDLE;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 8'd1;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
            if (cnt_q == len_q) begin
              state_q   <= WR_RESP;
              b_valid_q <= 1'b1;
              b_resp_q  <= (err_q || !beat_ok || !axi_req_i.w.last) ? RESP_SLVERR : RESP_OKAY;
            end else if (!beat_ok || axi_req_i.w.last) begin
              err_q <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (axi_req_i.b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_gnt;
    axi_rsp_o.ar_ready = ar_gnt;
    axi_rsp_o.w_ready  = (state_q == WR_DATA);
    axi_rsp_o.b_valid  = b_valid_q;
    axi_rsp_o.b.id     = id_q;
    axi_rsp_o.b.resp   = b_resp_q;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r.id     = id_q;
    axi_rsp_o.r.data   = r_data_q;
    axi_rsp_o.r.resp   = r_resp_q;
    axi_rsp_o.r.last   = r_last_q;
  end

  logic unused_bits;
  assign unused_bits = ^{axi_req_i.aw.atop, axi_req_i.aw.user, axi_req_i.ar.user,
                         axi_req_i.w.user, offs[OFF-1:0]};
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
module tb_axi_mem_responder;
  import config_pkg::*;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam logic [63:0] LASTW  = BASE + 64'd1024 * 64'd8 - 64'd8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_req_t req  [2];
  axi_rsp_t rsp  [2];
  logic     busy [2];
  int       cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi_mem_responder #(.ReadLatency(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req[0]), .axi_rsp_o(rsp[0]), .busy_o(busy[0]));
  axi_mem_responder #(.ReadLatency(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req[1]), .axi_rsp_o(rsp[1]), .busy_o(busy[1]));

  typedef struct packed {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;

  r_exp_t      exp_r [$];
  b_exp_t      exp_b [$];
  logic [63:0] mdl [2][1024];
  int          errors = 0;
  int          checks = 0;
  int          h;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 64'd1024);
  endfunction

  function automatic int widx(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) >> 3;
    return int'(o[9:0]);
  endfunction

  task automatic mdl_wr(input int d, input logic [63:0] a, input logic [63:0] data, input logic [7:0] strb);
    if (in_rng(a)) begin
      for (int b = 0; b < 8; b++) if (strb[b]) mdl[d][widx(a)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic set_ar(input int d, input logic [3:0] id, input logic [63:0] a, input logic [7:0] len);
    r_exp_t e;
    req[d].ar       = '0;
    req[d].ar.id    = id;
    req[d].ar.addr  = a;
    req[d].ar.len   = len;
    req[d].ar.size  = 3'd3;
    req[d].ar.burst = 2'b01;
    req[d].ar_valid = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      logic [63:0] ba;
      ba     = a + 64'(8 * i);
      e.id   = id;
      e.data = in_rng(ba) ? mdl[d][widx(ba)] : 64'd0;
      e.resp = in_rng(ba) ? OKAY : SLVERR;
      e.last = (i == int'(len));
      exp_r.push_back(e);
    end
  endtask

  task automatic set_aw(input int d, input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                        input logic [1:0] bresp);
    b_exp_t e;
    req[d].aw       = '0;
    req[d].aw.id    = id;
    req[d].aw.addr  = a;
    req[d].aw.len   = len;
    req[d].aw.size  = 3'd3;
    req[d].aw.burst = 2'b01;
    req[d].aw_valid = 1'b1;
    e.id   = id;
    e.resp = bresp;
    exp_b.push_back(e);
  endtask

  task automatic hs_a(input int d, input bit is_ar, output int hs);
    int t = 0;
    logic rdy;
    #1;
    rdy = is_ar ? rsp[d].ar_ready : rsp[d].aw_ready;
    while (!rdy && t < 100) begin
      @(negedge clk); #1; t++;
      rdy = is_ar ? rsp[d].ar_ready : rsp[d].aw_ready;
    end
    chk(is_ar ? "ar_grant_seen" : "aw_grant_seen", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    hs = cyc;
    if (is_ar) req[d].ar_valid = 1'b0;
    else       req[d].aw_valid = 1'b0;
  endtask

  task automatic wait_rv(input int d);
    int t = 0;
    while (!rsp[d].r_valid && t < 100) begin @(negedge clk); t++; end
    chk("r_valid_seen", 64'(rsp[d].r_valid), 64'd1);
  endtask

  task automatic rd_beats(input int d, input int n);
    r_exp_t e;
    for (int i = 0; i < n; i++) begin
      wait_rv(d);
      e = (exp_r.size() > 0) ? exp_r.pop_front() : '0;
      chk("r_data", rsp[d].r.data, e.data);
      chk("r_id",   64'(rsp[d].r.id), 64'(e.id));
      chk("r_resp", 64'(rsp[d].r.resp), 64'(e.resp));
      chk("r_last", 64'(rsp[d].r.last), 64'(e.last));
      req[d].r_ready = 1'b1;
      @(posedge clk); #1;
      req[d].r_ready = 1'b0;
    end
  endtask

  task automatic w_beat(input int d, input logic [63:0] a, input logic [63:0] data,
                        input logic [7:0] strb, input logic last);
    int t = 0;
    req[d].w.data  = data;
    req[d].w.strb  = strb;
    req[d].w.last  = last;
    req[d].w_valid = 1'b1;
    #1;
    while (!rsp[d].w_ready && t < 100) begin @(negedge clk); #1; t++; end
    chk("w_ready_seen", 64'(rsp[d].w_ready), 64'd1);
    mdl_wr(d, a, data, strb);
    @(posedge clk); #1;
    req[d].w_valid = 1'b0;
  endtask

  task automatic b_wait(input int d);
    int t = 0;
    b_exp_t e;
    while (!rsp[d].b_valid && t < 100) begin @(negedge clk); t++; end
    chk("b_valid_seen", 64'(rsp[d].b_valid), 64'd1);
    e = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
    chk("b_id",   64'(rsp[d].b.id), 64'(e.id));
    chk("b_resp", 64'(rsp[d].b.resp), 64'(e.resp));
    req[d].b_ready = 1'b1;
    @(posedge clk); #1;
    req[d].b_ready = 1'b0;
  endtask

  task automatic wr1(input int d, input logic [3:0] id, input logic [63:0] a, input logic [63:0] data,
                     input logic [7:0] strb, input logic [1:0] bresp);
    int hh;
    set_aw(d, id, a, 8'd0, bresp);
    hs_a(d, 1'b0, hh);
    w_beat(d, a, data, strb, 1'b1);
    b_wait(d);
  endtask

  task automatic rd(input int d, input logic [3:0] id, input logic [63:0] a, input logic [7:0] len);
    int hh;
    set_ar(d, id, a, len);
    hs_a(d, 1'b1, hh);
    rd_beats(d, int'(len) + 1);
  endtask

  initial begin
    req[0] = '0;
    req[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",     64'(busy[0]), 64'd0);
    chk("rst_r_valid",  64'(rsp[0].r_valid), 64'd0);
    chk("rst_b_valid",  64'(rsp[0].b_valid), 64'd0);
    chk("rst_w_ready",  64'(rsp[0].w_ready), 64'd0);
    chk("rst_ar_ready", 64'(rsp[0].ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(rsp[0].aw_ready), 64'd0);
    chk("rst_r_data",   rsp[0].r.data, 64'd0);
    chk("rst_b_resp",   64'(rsp[0].b.resp), 64'd0);
    chk("rst_busy_rl3", 64'(busy[1]), 64'd0);

    // write-back burst then refill of the same line
    set_aw(0, 4'd1, BASE + 64'h40, 8'd1, OKAY);
    hs_a(0, 1'b0, h);
    w_beat(0, BASE + 64'h40, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    w_beat(0, BASE + 64'h48, 64'h2222_2222_2222_2222, 8'hFF, 1'b1);
    b_wait(0);
    set_ar(0, 4'd2, BASE + 64'h40, 8'd1);
    hs_a(0, 1'b1, h);
    wait_rv(0);
    chk("rd_latency_rl0", 64'(cyc - h), 64'd2);
    rd_beats(0, 2);

    // read latency 3 with r_ready backpressure on beat 0
    set_aw(1, 4'd3, BASE + 64'h100, 8'd1, OKAY);
    hs_a(1, 1'b0, h);
    w_beat(1, BASE + 64'h100, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    w_beat(1, BASE + 64'h108, 64'hCAFE_F00D_0000_0002, 8'hFF, 1'b1);
    b_wait(1);
    set_ar(1, 4'd5, BASE + 64'h100, 8'd1);
    hs_a(1, 1'b1, h);
    wait_rv(1);
    chk("rd_latency_rl3", 64'(cyc - h), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(rsp[1].r_valid), 64'd1);
      chk("bp_data",  rsp[1].r.data, exp_r[0].data);
      chk("bp_id",    64'(rsp[1].r.id), 64'(exp_r[0].id));
      chk("bp_last",  64'(rsp[1].r.last), 64'(exp_r[0].last));
      @(negedge clk);
    end
    rd_beats(1, 2);

    // round-robin between simultaneous AR and AW
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    set_ar(0, 4'd6, BASE + 64'h40, 8'd0);
    set_aw(0, 4'd7, BASE + 64'h200, 8'd0, OKAY);
    #1;
    chk("rr1_ar_ready", 64'(rsp[0].ar_ready), 64'd1);
    chk("rr1_aw_ready", 64'(rsp[0].aw_ready), 64'd0);
    hs_a(0, 1'b1, h);
    set_ar(0, 4'd8, BASE + 64'h48, 8'd0);
    rd_beats(0, 1);
    #1;
    chk("rr2_aw_ready", 64'(rsp[0].aw_ready), 64'd1);
    chk("rr2_ar_ready", 64'(rsp[0].ar_ready), 64'd0);
    hs_a(0, 1'b0, h);
    w_beat(0, BASE + 64'h200, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 1'b1);
    b_wait(0);
    hs_a(0, 1'b1, h);
    rd_beats(0, 1);

    // out-of-range beats and writes
    wr1(0, 4'd9, LASTW, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, OKAY);
    rd(0, 4'd10, LASTW, 8'd1);
    wr1(0, 4'd11, 64'h7FFF_FFF8, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, SLVERR);
    rd(0, 4'd12, LASTW, 8'd0);

    // byte strobes and a w.last that arrives early
    wr1(0, 4'd1, BASE + 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, OKAY);
    wr1(0, 4'd2, BASE + 64'h80, 64'h0123_4567_89AB_CDEF, 8'h0F, OKAY);
    rd(0, 4'd3, BASE + 64'h80, 8'd0);
    set_aw(0, 4'd4, BASE + 64'hC0, 8'd1, SLVERR);
    hs_a(0, 1'b0, h);
    w_beat(0, BASE + 64'hC0, 64'h3333_3333_3333_3333, 8'hFF, 1'b1);
    w_beat(0, BASE + 64'hC8, 64'h4444_4444_4444_4444, 8'hFF, 1'b0);
    b_wait(0);
    rd(0, 4'd5, BASE + 64'hC8, 8'd0);

    // reset in the middle of a read burst
    set_ar(0, 4'd5, BASE + 64'h40, 8'd3);
    hs_a(0, 1'b1, h);
    wait_rv(0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_r_valid", 64'(rsp[0].r_valid), 64'd0);
    chk("midrst_busy",    64'(busy[0]), 64'd0);
    exp_r.delete();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    rd(0, 4'd6, BASE + 64'h48, 8'd0);

    chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
